apb_ram_slave: RTL and testbench
================================

# apb_ram_slave

APB slave front-end that sits directly upstream of the byte-addressed data RAM and converts APB transfers into RAM accesses. It latches each transfer in the setup phase and inserts a programmable number of wait states. It drives the RAM's address, size code, write enable and write data, captures RAM read data into a registered `PRDATA`, and optionally flags misaligned or illegal-size accesses on `PSLVERR`.

## Interface
Parameters:
- `WAIT_STATES`, default 0: extra access-phase cycles before the data-capture cycle (0..15).

Ports:
- `PCLK` in 1: clock; single clock domain.
- `PRESETn` in 1: asynchronous, active-low reset.
- `PSEL` in 1: slave select.
- `PENABLE` in 1: access phase.
- `PWRITE` in 1: 1 = write.
- `PADDR` in 8: byte address.
- `PSIZE` in 3: access size, funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `PWDATA` in 32: write data, LSB-justified.
- `PRDATA` out 32: registered read data.
- `PREADY` out 1: transfer complete.
- `PSLVERR` out 1: transfer error; valid only with `PREADY`.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out 8: RAM byte address.
- `ram_strb` out 3: RAM size code, equal to the latched `PSIZE`.
- `ram_wData` out 32: RAM write data.
- `ram_rData` in 32: combinational RAM read data, already sign- or zero-extended by the RAM.

## Operation
- FSM states: IDLE, WAIT, READY.
- IDLE:
  - On `PSEL & ~PENABLE` (setup), latch `PADDR`, `PSIZE`, `PWRITE`, `PWDATA` and the error flag.
  - Clear the wait counter.
  - Go to WAIT.
- WAIT:
  - `ram_addr`/`ram_strb`/`ram_wData` are driven from the latched registers. They hold those values through READY.
  - If counter == `WAIT_STATES`:
    - Read without error: capture `ram_rData` into `PRDATA`.
    - Read with error: load 0 into `PRDATA`.
    - Go to READY.
  - Otherwise increment the counter.
- READY:
  - `PREADY`=1 and `PSLVERR`=latched error.
  - `ram_we` = latched write & ~error, so the write commits on the edge that ends READY.
  - Next state is IDLE.
- Abort: `PSEL`=0 in WAIT or READY forces IDLE. No write is issued and `PREADY` is not asserted.
- Error conditions (only with the macro, see Configuration):
  - H/HU with `PADDR[0]`≠0.
  - W with `PADDR[1:0]`≠0.
  - `PSIZE` ∈ {011, 110, 111}.
- Write-data masking: bytes above the access size are not forced to 0. The RAM ignores them.
- `PRDATA` holds its value until the next read capture. Writes do not change it.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; `PRDATA`=0, `PREADY`=0, `PSLVERR`=0, `ram_we`=0, `ram_addr`=0, `ram_strb`=0, `ram_wData`=0. Any in-flight write is dropped.
- Setup in cycle T0 gives `PREADY`=1 in cycle T2+`WAIT_STATES`. With `WAIT_STATES`=0 there is one APB wait state.
- `ram_we` is high for exactly one cycle per error-free write, coincident with `PREADY`.
- Back-to-back transfers: the FSM returns to IDLE after READY, so a setup in the cycle after READY is accepted without a gap.
- Setup detected while `PENABLE`=1 in IDLE is ignored.
- Throughput: one transfer per 3+`WAIT_STATES` cycles.

## Configuration
- Macro: `APB_RAM_ALIGN_CHECK_EN`.
- Defined:
  - Alignment and illegal-size detection as above.
  - An errored write does not assert `ram_we`.
  - An errored read returns `PRDATA`=0.
- Undefined:
  - `PSLVERR` is tied to 0 and every access is forwarded.
  - Misaligned multi-byte accesses wrap modulo 256 inside the RAM.
  - An illegal size reads as 0, because the RAM output defaults to 0, and its write is ignored.

## Structure
- Package `apb_ram_pkg`:
  - State enum `apb_ram_state_e`.
  - Size constants `SIZE_B`, `SIZE_H`, `SIZE_W`, `SIZE_BU`, `SIZE_HU`.
  - Counter width constant.
- Sub-module `apb_ram_align_chk`: combinational, takes (addr[1:0], size) and returns err. Instantiated only under `APB_RAM_ALIGN_CHECK_EN`.

## Test plan
- Write W 0xDEADBEEF @0x10, then read W @0x10 → `ram_we` pulses once; `PRDATA`=0xDEADBEEF; `PREADY` at T2 with `WAIT_STATES`=0.
- Write B 0x80 @0x21, then read B @0x21 → `PRDATA`=0xFFFFFF80. Read BU @0x21 → 0x00000080.
- With the macro defined: write H 0x1234 @0x03 → `PSLVERR`=1 with `PREADY`, `ram_we` never asserted. A subsequent read W @0x00 returns the old contents, and `PSLVERR` on that read is 0.
- `WAIT_STATES`=3: read W @0x04 with setup at T0 → `PREADY` exactly at T5. Back-to-back write setup at T6 is accepted, with `PREADY` at T11.
- `PRESETn` pulsed low during WAIT of a write @0x40 → outputs go to reset values immediately, no `ram_we`, and a later read @0x40 returns the pre-write value.
- `PSEL` dropped during WAIT → FSM returns to IDLE; no `PREADY`, no `ram_we`. The next transfer completes normally.

Source files
------------

// File: rtl/apb_ram_pkg.sv
// -----------------------------------------------------------------------------
// apb_ram_pkg
//   Shared types and constants for the APB-to-RAM front-end.
//   - apb_ram_state_e : transfer FSM states (IDLE / WAIT / READY)
//   - SIZE_*          : access size codes (RISC-V funct3 load/store encoding)
//   - CNT_W           : width of the wait-state counter (covers 0..15)
//   - size_is_legal() : true for the five size codes the RAM understands
// -----------------------------------------------------------------------------
package apb_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } apb_ram_state_e;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  localparam int unsigned CNT_W = 4;

  function automatic logic size_is_legal(input logic [2:0] size);
    logic legal;
    legal = 1'b0;
    case (size)
      SIZE_B, SIZE_H, SIZE_W, SIZE_BU, SIZE_HU: legal = 1'b1;
      default:                                  legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/apb_ram_align_chk.sv
// -----------------------------------------------------------------------------
// apb_ram_align_chk
//   Combinational access checker. Flags an access as erroneous when the size
//   code is illegal or the byte address is not naturally aligned to the size.
//   Ports:
//     addr_i [1:0] : low address bits of the access
//     size_i [2:0] : funct3 size code
//     err_o        : 1 = misaligned or illegal-size access
// -----------------------------------------------------------------------------
module apb_ram_align_chk
  import apb_ram_pkg::*;
(
  input  logic [1:0] addr_i,
  input  logic [2:0] size_i,
  output logic       err_o
);

  always_comb begin
    err_o = 1'b0;
    if (!size_is_legal(size_i)) begin
      err_o = 1'b1;
    end else begin
      case (size_i)
        SIZE_H, SIZE_HU: err_o = addr_i[0];
        SIZE_W:          err_o = |addr_i;
        default:         err_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/apb_ram_slave.sv
// -----------------------------------------------------------------------------
// apb_ram_slave
//   APB slave front-end for the byte-addressed data RAM. Latches each transfer
//   in the setup phase, inserts WAIT_STATES extra access cycles, then completes
//   with PREADY. Reads capture the RAM's (already extended) data into a
//   registered PRDATA; writes pulse ram_we for one cycle together with PREADY.
//
//   Parameters:
//     WAIT_STATES : extra access-phase cycles before data capture (0..15)
//
//   Ports:
//     PCLK, PRESETn           : clock, asynchronous active-low reset
//     PSEL, PENABLE, PWRITE   : APB control
//     PADDR[7:0], PSIZE[2:0]  : byte address, funct3 size code
//     PWDATA[31:0]            : write data, LSB-justified
//     PRDATA[31:0]            : registered read data
//     PREADY, PSLVERR         : completion / error (PSLVERR valid with PREADY)
//     ram_we, ram_addr,
//     ram_strb, ram_wData     : RAM write enable, address, size code, data
//     ram_rData[31:0]         : combinational RAM read data
//
//   Build option:
//     APB_RAM_ALIGN_CHECK_EN  : when defined, misaligned or illegal-size
//                               accesses raise PSLVERR, errored writes are
//                               dropped and errored reads return 0. When
//                               undefined, every access is forwarded and
//                               PSLVERR stays 0.
// -----------------------------------------------------------------------------
module apb_ram_slave
  import apb_ram_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [2:0]  PSIZE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        ram_we,
  output logic [7:0]  ram_addr,
  output logic [2:0]  ram_strb,
  output logic [31:0] ram_wData,
  input  logic [31:0] ram_rData
);

  localparam logic [CNT_W-1:0] WS_LAST = CNT_W'(WAIT_STATES);

  apb_ram_state_e    state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        addr_q;
  logic [2:0]        size_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic              ready_q;
  logic              slverr_q;
  logic              we_q;

  logic              setup_err;
  logic              setup;

  assign setup = PSEL & ~PENABLE;

`ifdef APB_RAM_ALIGN_CHECK_EN
  apb_ram_align_chk u_align_chk (
    .addr_i (PADDR[1:0]),
    .size_i (PSIZE),
    .err_o  (setup_err)
  );
`else
  assign setup_err = 1'b0;
`endif

  // Single FSM process; all handshake outputs are registered here and the
  // address/size/data registers double as the RAM-side drivers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q  <= 1'b0;
          slverr_q <= 1'b0;
          we_q     <= 1'b0;
          if (setup) begin
            addr_q  <= PADDR;
            size_q  <= PSIZE;
            wdata_q <= PWDATA;
            write_q <= PWRITE;
            err_q   <= setup_err;
            cnt_q   <= '0;
            state_q <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (!PSEL) begin
            // Abort takes priority over completion: nothing is committed.
            state_q <= ST_IDLE;
          end else if (cnt_q == WS_LAST) begin
            if (!write_q) begin
              rdata_q <= err_q ? '0 : ram_rData;
            end
            ready_q  <= 1'b1;
            slverr_q <= err_q;
            we_q     <= write_q & ~err_q;
            state_q  <= ST_READY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_READY: begin
          ready_q  <= 1'b0;
          slverr_q <= 1'b0;
          we_q     <= 1'b0;
          state_q  <= ST_IDLE;
        end

        default: begin
          ready_q  <= 1'b0;
          slverr_q <= 1'b0;
          we_q     <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  // The completion flags are qualified with PSEL so that a master dropping
  // PSEL during READY sees neither PREADY nor a RAM write in that cycle.
  assign PREADY    = ready_q  & PSEL;
  assign PSLVERR   = slverr_q & PSEL;
  assign ram_we    = we_q     & PSEL;
  assign PRDATA    = rdata_q;
  assign ram_addr  = addr_q;
  assign ram_strb  = size_q;
  assign ram_wData = wdata_q;

endmodule

// File: tb/tb_apb_ram_slave.sv
module tb_apb_ram_slave;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge PCLK) cyc++;

  // DUT 0: WAIT_STATES = 0, DUT 3: WAIT_STATES = 3
  logic        psel0 = 0, penable0 = 0, pwrite0 = 0;
  logic [7:0]  paddr0 = '0;
  logic [2:0]  psize0 = '0;
  logic [31:0] pwdata0 = '0;
  logic [31:0] prdata0, ram_wdata0, ram_rdata0;
  logic        pready0, pslverr0, ram_we0;
  logic [7:0]  ram_addr0;
  logic [2:0]  ram_strb0;

  logic        psel3 = 0, penable3 = 0, pwrite3 = 0;
  logic [7:0]  paddr3 = '0;
  logic [2:0]  psize3 = '0;
  logic [31:0] pwdata3 = '0;
  logic [31:0] prdata3, ram_wdata3, ram_rdata3;
  logic        pready3, pslverr3, ram_we3;
  logic [7:0]  ram_addr3;
  logic [2:0]  ram_strb3;

  apb_ram_slave #(.WAIT_STATES(0)) u_dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(penable0),
    .PWRITE(pwrite0), .PADDR(paddr0), .PSIZE(psize0), .PWDATA(pwdata0),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0), .ram_we(ram_we0),
    .ram_addr(ram_addr0), .ram_strb(ram_strb0), .ram_wData(ram_wdata0),
    .ram_rData(ram_rdata0));

  apb_ram_slave #(.WAIT_STATES(3)) u_dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel3), .PENABLE(penable3),
    .PWRITE(pwrite3), .PADDR(paddr3), .PSIZE(psize3), .PWDATA(pwdata3),
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3), .ram_we(ram_we3),
    .ram_addr(ram_addr3), .ram_strb(ram_strb3), .ram_wData(ram_wdata3),
    .ram_rData(ram_rdata3));

  // Byte-addressed RAM models, one per DUT
  logic [7:0] mem0 [256];
  logic [7:0] mem3 [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem3[i] = 8'h00;
    end
  end

  function automatic logic [31:0] ram_read(input logic [7:0] m [256],
                                           input logic [7:0] a, input logic [2:0] s);
    logic [7:0] b0, b1, b2, b3;
    logic [31:0] r;
    b0 = m[a];
    b1 = m[8'(a + 8'd1)];
    b2 = m[8'(a + 8'd2)];
    b3 = m[8'(a + 8'd3)];
    case (s)
      3'b000:  r = {{24{b0[7]}}, b0};
      3'b001:  r = {{16{b1[7]}}, b1, b0};
      3'b010:  r = {b3, b2, b1, b0};
      3'b100:  r = {24'h0, b0};
      3'b101:  r = {16'h0, b1, b0};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  always_comb ram_rdata0 = ram_read(mem0, ram_addr0, ram_strb0);
  always_comb ram_rdata3 = ram_read(mem3, ram_addr3, ram_strb3);

  always @(posedge PCLK) begin
    if (ram_we0) begin
      case (ram_strb0)
        3'b000: mem0[ram_addr0] <= ram_wdata0[7:0];
        3'b001: begin
          mem0[ram_addr0] <= ram_wdata0[7:0];
          mem0[8'(ram_addr0 + 8'd1)] <= ram_wdata0[15:8];
        end
        3'b010: begin
          mem0[ram_addr0] <= ram_wdata0[7:0];
          mem0[8'(ram_addr0 + 8'd1)] <= ram_wdata0[15:8];
          mem0[8'(ram_addr0 + 8'd2)] <= ram_wdata0[23:16];
          mem0[8'(ram_addr0 + 8'd3)] <= ram_wdata0[31:24];
        end
        default: ;
      endcase
    end
    if (ram_we3) begin
      case (ram_strb3)
        3'b000: mem3[ram_addr3] <= ram_wdata3[7:0];
        3'b001: begin
          mem3[ram_addr3] <= ram_wdata3[7:0];
          mem3[8'(ram_addr3 + 8'd1)] <= ram_wdata3[15:8];
        end
        3'b010: begin
          mem3[ram_addr3] <= ram_wdata3[7:0];
          mem3[8'(ram_addr3 + 8'd1)] <= ram_wdata3[15:8];
          mem3[8'(ram_addr3 + 8'd2)] <= ram_wdata3[23:16];
          mem3[8'(ram_addr3 + 8'd3)] <= ram_wdata3[31:24];
        end
        default: ;
      endcase
    end
  end

  // ram_we may only appear together with PREADY
  always @(negedge PCLK) begin
    if (ram_we0) begin
      checks++;
      if (!pready0) begin
        failures++;
        $display("FAIL we_without_ready dut0 t=%0t act=0 exp=1", $time);
      end
    end
    if (ram_we3) begin
      checks++;
      if (!pready3) begin
        failures++;
        $display("FAIL we_without_ready dut3 t=%0t act=0 exp=1", $time);
      end
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] rd;
    logic        rdy;
    logic        err;
    logic        we;
    logic [7:0]  a;
    logic [2:0]  s;
    logic [31:0] wd;
  } obs_t;

  function automatic obs_t obs(input int k);
    obs_t o;
    if (k == 0) o = {prdata0, pready0, pslverr0, ram_we0, ram_addr0, ram_strb0, ram_wdata0};
    else        o = {prdata3, pready3, pslverr3, ram_we3, ram_addr3, ram_strb3, ram_wdata3};
    return o;
  endfunction

  task automatic drv(input int k, input logic sel, input logic en, input logic wr,
                     input logic [7:0] a, input logic [2:0] s, input logic [31:0] wd);
    if (k == 0) begin
      psel0 = sel; penable0 = en; pwrite0 = wr; paddr0 = a; psize0 = s; pwdata0 = wd;
    end else begin
      psel3 = sel; penable3 = en; pwrite3 = wr; paddr3 = a; psize3 = s; pwdata3 = wd;
    end
  endtask

  // Called #1 after a clock edge; drives setup in the current cycle and
  // returns #1 after the edge that ends the READY cycle, bus idle.
  task automatic xfer(input int k, input logic wr, input logic [7:0] a, input logic [2:0] s,
                      input logic [31:0] wd, output logic [31:0] rd, output logic err,
                      output int lat, output int wes, output int tr);
    obs_t o;
    drv(k, 1'b1, 1'b0, wr, a, s, wd);
    @(posedge PCLK); #1;
    drv(k, 1'b1, 1'b1, wr, a, s, wd);
    lat = 1;
    wes = 0;
    o = obs(k);
    chk($sformatf("latched_regs k=%0d a=%0h", k, a), {o.a, o.s, o.wd}, {a, s, wd});
    while (!o.rdy && lat < 40) begin
      if (o.we) wes++;
      @(posedge PCLK); #1;
      lat++;
      o = obs(k);
    end
    if (!o.rdy) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout k=%0d act=0 exp=1", k);
    end
    if (o.we) wes++;
    rd = o.rd;
    err = o.err;
    tr = cyc;
    @(posedge PCLK); #1;
    drv(k, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 32'h0);
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [2:0]  s;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [31:0] rd;
    logic err;
    int lat, wes, tr, tr2, t0, cnt_rdy, cnt_we;

    // wr, addr, size, wdata, expected PRDATA (held value for writes)
    tbl[0]  = '{1'b1, 8'h10, 3'b010, 32'hDEADBEEF, 32'h00000000};
    tbl[1]  = '{1'b0, 8'h10, 3'b010, 32'h00000000, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 8'h21, 3'b000, 32'h12345680, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 8'h21, 3'b000, 32'h00000000, 32'hFFFFFF80};
    tbl[4]  = '{1'b0, 8'h21, 3'b100, 32'h00000000, 32'h00000080};
    tbl[5]  = '{1'b1, 8'h00, 3'b010, 32'hA5A5A5A5, 32'h00000080};
    tbl[6]  = '{1'b1, 8'h22, 3'b001, 32'hFFFF1234, 32'h00000080};
    tbl[7]  = '{1'b0, 8'h22, 3'b101, 32'h00000000, 32'h00001234};
    tbl[8]  = '{1'b0, 8'h20, 3'b010, 32'h00000000, 32'h12348000};
    tbl[9]  = '{1'b1, 8'h30, 3'b001, 32'h00008001, 32'h12348000};
    tbl[10] = '{1'b0, 8'h30, 3'b001, 32'h00000000, 32'hFFFF8001};

    // Reset state
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_dut0", 96'(obs(0)), 96'h0);
    chk("reset_dut3", 96'(obs(3)), 96'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Table-driven transfers on the zero-wait-state instance
    for (int i = 0; i < 11; i++) begin
      xfer(0, tbl[i].wr, tbl[i].a, tbl[i].s, tbl[i].wd, rd, err, lat, wes, tr);
      chk($sformatf("vec%0d_prdata", i), 96'(rd), 96'(tbl[i].exp_rd));
      chk($sformatf("vec%0d_pslverr", i), 96'(err), 96'h0);
      chk($sformatf("vec%0d_latency", i), 96'(lat), 96'd2);
      chk($sformatf("vec%0d_we_pulses", i), 96'(wes), tbl[i].wr ? 96'd1 : 96'd0);
    end

    // Misaligned / illegal accesses (mem0[00..03]=A5, mem0[04]=00)
    xfer(0, 1'b1, 8'h03, 3'b001, 32'h00001234, rd, err, lat, wes, tr);
`ifdef APB_RAM_ALIGN_CHECK_EN
    chk("misalign_wr_err", 96'(err), 96'h1);
    chk("misalign_wr_we", 96'(wes), 96'd0);
    chk("misalign_wr_prdata_hold", 96'(rd), 96'hFFFF8001);
    xfer(0, 1'b0, 8'h00, 3'b010, 32'h0, rd, err, lat, wes, tr);
    chk("after_err_rd", 96'(rd), 96'hA5A5A5A5);
    chk("after_err_rd_err", 96'(err), 96'h0);
    xfer(0, 1'b0, 8'h01, 3'b010, 32'h0, rd, err, lat, wes, tr);
    chk("misalign_rd_w", 96'(rd), 96'h0);
    chk("misalign_rd_w_err", 96'(err), 96'h1);
    xfer(0, 1'b0, 8'h00, 3'b011, 32'h0, rd, err, lat, wes, tr);
    chk("illegal_size_rd", 96'(rd), 96'h0);
    chk("illegal_size_rd_err", 96'(err), 96'h1);
`else
    chk("misalign_wr_err", 96'(err), 96'h0);
    chk("misalign_wr_we", 96'(wes), 96'd1);
    xfer(0, 1'b0, 8'h00, 3'b010, 32'h0, rd, err, lat, wes, tr);
    chk("after_misalign_rd", 96'(rd), 96'h34A5A5A5);
    chk("after_misalign_rd_err", 96'(err), 96'h0);
    xfer(0, 1'b0, 8'h01, 3'b010, 32'h0, rd, err, lat, wes, tr);
    chk("misalign_rd_w", 96'(rd), 96'h1234A5A5);
    chk("misalign_rd_w_err", 96'(err), 96'h0);
    xfer(0, 1'b0, 8'h00, 3'b011, 32'h0, rd, err, lat, wes, tr);
    chk("illegal_size_rd", 96'(rd), 96'h0);
    chk("illegal_size_rd_err", 96'(err), 96'h0);
`endif

    // Three wait states: latency and back-to-back acceptance
    xfer(1, 1'b1, 8'h40, 3'b010, 32'h55667788, rd, err, lat, wes, tr);
    chk("ws3_wr40_latency", 96'(lat), 96'd5);
    chk("ws3_wr40_we", 96'(wes), 96'd1);
    xfer(1, 1'b1, 8'h50, 3'b010, 32'h0BADF00D, rd, err, lat, wes, tr);
    xfer(1, 1'b1, 8'h04, 3'b010, 32'hC0FFEE00, rd, err, lat, wes, tr);
    t0 = cyc;
    xfer(1, 1'b0, 8'h04, 3'b010, 32'h0, rd, err, lat, wes, tr);
    xfer(1, 1'b1, 8'h08, 3'b010, 32'h13579BDF, rd, err, lat, wes, tr2);
    chk("ws3_rd04_ready_at_T5", 96'(tr - t0), 96'd5);
    chk("ws3_b2b_wr_ready_at_T11", 96'(tr2 - t0), 96'd11);
    xfer(1, 1'b0, 8'h08, 3'b010, 32'h0, rd, err, lat, wes, tr);
    chk("ws3_rd08", 96'(rd), 96'h13579BDF);

    // Asynchronous reset in the middle of a write's WAIT phase
    drv(1, 1'b1, 1'b0, 1'b1, 8'h40, 3'b010, 32'hAAAAAAAA);
    @(posedge PCLK); #1;
    drv(1, 1'b1, 1'b1, 1'b1, 8'h40, 3'b010, 32'hAAAAAAAA);
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    #1;
    chk("async_reset_outputs", 96'(obs(1)), 96'h0);
    drv(1, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(1, 1'b0, 8'h40, 3'b010, 32'h0, rd, err, lat, wes, tr);
    chk("after_reset_rd40", 96'(rd), 96'h55667788);

    // PSEL dropped during WAIT aborts the transfer
    drv(1, 1'b1, 1'b0, 1'b1, 8'h50, 3'b010, 32'hFFFFFFFF);
    @(posedge PCLK); #1;
    drv(1, 1'b1, 1'b1, 1'b1, 8'h50, 3'b010, 32'hFFFFFFFF);
    @(posedge PCLK); #1;
    drv(1, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 32'h0);
    cnt_rdy = 0;
    cnt_we = 0;
    for (int i = 0; i < 8; i++) begin
      if (pready3) cnt_rdy++;
      if (ram_we3) cnt_we++;
      @(posedge PCLK); #1;
    end
    chk("abort_no_ready", 96'(cnt_rdy), 96'd0);
    chk("abort_no_we", 96'(cnt_we), 96'd0);
    xfer(1, 1'b0, 8'h50, 3'b010, 32'h0, rd, err, lat, wes, tr);
    chk("abort_next_rd50", 96'(rd), 96'h0BADF00D);
    chk("abort_next_latency", 96'(lat), 96'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
